// File: rtl/icache_line_responder_pkg.sv
// Shared types and helpers for the line-fill instruction cache.
// Holds line geometry, the fill FSM encoding and the address split.
package icache_line_responder_pkg;

  localparam int LINE_BYTES     = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFF_BITS       = $clog2(LINE_BYTES);
  localparam int LINE_ADDR_W    = 32 - OFF_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    INSTALL = 2'd3
  } fill_state_e;

  // Line address: index sits in the low bits, tag above it.
  function automatic logic [LINE_ADDR_W-1:0] line_addr(
    input logic [31:0] a
  );
    return a[31:OFF_BITS];
  endfunction

endpackage

// File: rtl/icache_line_responder_tag_array.sv
// Valid bits and tags with combinational lookup.
// Single write port used when a filled line is installed.
module icache_tag_array #(
  parameter int LINES = 16,
  parameter int IDX   = 4,
  parameter int TAGW  = 24
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [IDX-1:0]  lkp_idx_i,
  input  logic [TAGW-1:0] lkp_tag_i,
  output logic            hit_o,
  input  logic            wr_en_i,
  input  logic [IDX-1:0]  wr_idx_i,
  input  logic [TAGW-1:0] wr_tag_i
);

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q [LINES];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  assign hit_o = valid_q[lkp_idx_i] &&
                 (tag_q[lkp_idx_i] == lkp_tag_i);

endmodule

// File: rtl/icache_line_responder.sv
// Direct-mapped I-cache answering whole-line reads with 0-cycle hits.
// Misses are filled one word at a time from instruction memory.
module icache_line_responder
  import icache_line_responder_pkg::*;
#(
  parameter  int LINES = 16,
  localparam int IDX   = $clog2(LINES),
  localparam int TAGW  = 28 - IDX
) (
  input  logic        Clk,
  input  logic        Resetb,
  input  logic [31:0] Ifetch_WpPcIn,
  input  logic        Ifetch_ReadCache,
  input  logic        IFQ_Flush,
  output logic [31:0] Cache_Cd0,
  output logic [31:0] Cache_Cd1,
  output logic [31:0] Cache_Cd2,
  output logic [31:0] Cache_Cd3,
  output logic        Cache_ReadHit,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_RdData,
  input  logic        Imem_RdValid
);

  fill_state_e            state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [LINE_ADDR_W-1:0] miss_q, miss_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            fill_q [WORDS_PER_LINE];
  logic [31:0]            data_q [LINES][WORDS_PER_LINE];

  logic [LINE_ADDR_W-1:0] req_line;
  logic [IDX-1:0]         req_idx;
  logic [IDX-1:0]         miss_idx;
  logic [TAGW-1:0]        req_tag;
  logic [TAGW-1:0]        miss_tag;
  logic                   tag_hit;
  logic                   rd_req;
  logic                   install;

  assign req_line = line_addr(Ifetch_WpPcIn);
  assign req_idx  = req_line[IDX-1:0];
  assign req_tag  = req_line[LINE_ADDR_W-1:IDX];
  assign miss_idx = miss_q[IDX-1:0];
  assign miss_tag = miss_q[LINE_ADDR_W-1:IDX];
  assign rd_req   = Ifetch_ReadCache && !IFQ_Flush;
  assign install  = (state_q == INSTALL);

  icache_tag_array #(
    .LINES (LINES),
    .IDX   (IDX),
    .TAGW  (TAGW)
  ) u_tags (
    .clk_i     (Clk),
    .rst_ni    (Resetb),
    .lkp_idx_i (req_idx),
    .lkp_tag_i (req_tag),
    .hit_o     (tag_hit),
    .wr_en_i   (install),
    .wr_idx_i  (miss_idx),
    .wr_tag_i  (miss_tag)
  );

  always_ff @(posedge Clk) begin
    if (!Resetb) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge Clk) begin
    miss_q <= miss_d;
    if (state_q == WAIT && Imem_RdValid) begin
      fill_q[cnt_q] <= Imem_RdData;
    end
    if (install) begin
      data_q[miss_idx] <= fill_q;
    end
  end

  // Next request address is staged on entry to REQ and held afterwards.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (rd_req && !tag_hit) begin
          miss_d  = req_line;
          cnt_d   = 2'd0;
          addr_d  = {req_line, 4'b0000};
          state_d = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (Imem_RdValid) begin
          if (cnt_q == 2'd3) begin
            state_d = INSTALL;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            addr_d  = {miss_q, cnt_q + 2'd1, 2'b00};
            state_d = REQ;
          end
        end
      end
      INSTALL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Imem_Req      = (state_q == REQ);
    Imem_Addr     = addr_q;
    Cache_ReadHit = rd_req && (state_q == IDLE) && tag_hit;
    Cache_Cd0     = data_q[req_idx][0];
    Cache_Cd1     = data_q[req_idx][1];
    Cache_Cd2     = data_q[req_idx][2];
    Cache_Cd3     = data_q[req_idx][3];
  end

endmodule

// File: tb/tb_icache_line_responder.sv
// Directed bench for icache_line_responder.
// Memory model answers each word request after a fixed latency.
module tb_icache_line_responder;

  localparam int LAT = 2;
  localparam int PEN = 2 + 4 * (LAT + 1);

  logic        Clk = 1'b0;
  logic        Resetb = 1'b0;
  logic [31:0] Ifetch_WpPcIn = '0;
  logic        Ifetch_ReadCache = 1'b0;
  logic        IFQ_Flush = 1'b0;
  logic [31:0] Cache_Cd0, Cache_Cd1, Cache_Cd2, Cache_Cd3;
  logic        Cache_ReadHit;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_RdData = '0;
  logic        Imem_RdValid = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  int          f_cyc;
  int          f_nreq;
  logic [31:0] f_addr [8];
  logic [31:0] f_cd [4];

  int          pend = 0;
  logic [31:0] pdata = '0;

  icache_line_responder dut (
    .Clk              (Clk),
    .Resetb           (Resetb),
    .Ifetch_WpPcIn    (Ifetch_WpPcIn),
    .Ifetch_ReadCache (Ifetch_ReadCache),
    .IFQ_Flush        (IFQ_Flush),
    .Cache_Cd0        (Cache_Cd0),
    .Cache_Cd1        (Cache_Cd1),
    .Cache_Cd2        (Cache_Cd2),
    .Cache_Cd3        (Cache_Cd3),
    .Cache_ReadHit    (Cache_ReadHit),
    .Imem_Req         (Imem_Req),
    .Imem_Addr        (Imem_Addr),
    .Imem_RdData      (Imem_RdData),
    .Imem_RdValid     (Imem_RdValid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a < 32'h10) return (32'(a[3:2]) + 32'd1) * 32'h11;
    return 32'hA500_0000 | a;
  endfunction

  // Request seen in cycle k is answered during cycle k+LAT.
  always @(negedge Clk) begin
    Imem_RdValid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        Imem_RdValid = 1'b1;
        Imem_RdData  = pdata;
      end
    end
    if (Imem_Req === 1'b1) begin
      pend  = LAT;
      pdata = mem(Imem_Addr);
    end
  end

  task automatic run_fill(input logic [31:0] a);
    f_cyc  = -1;
    f_nreq = 0;
    @(negedge Clk);
    Ifetch_WpPcIn    = a;
    Ifetch_ReadCache = 1'b1;
    IFQ_Flush        = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (Imem_Req === 1'b1 && f_nreq < 8) begin
        f_addr[f_nreq] = Imem_Addr;
        f_nreq++;
      end
      if (Cache_ReadHit === 1'b1) begin
        f_cyc = i;
        f_cd  = '{Cache_Cd0, Cache_Cd1, Cache_Cd2, Cache_Cd3};
        break;
      end
      @(negedge Clk);
    end
    Ifetch_ReadCache = 1'b0;
  endtask

  task automatic test_reset();
    Resetb = 1'b0;
    repeat (2) @(negedge Clk);
    Ifetch_WpPcIn    = 32'h0;
    Ifetch_ReadCache = 1'b1;
    #1;
    n_tests++;
    if (Cache_ReadHit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hit got=%b exp=0", Cache_ReadHit);
    end
    n_tests++;
    if (Imem_Req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req got=%b exp=0", Imem_Req);
    end
    n_tests++;
    if (Imem_Addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr got=%h exp=0", Imem_Addr);
    end
    @(negedge Clk);
    Ifetch_ReadCache = 1'b0;
    Resetb = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic [31:0] exp_d [4];
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_fill(32'h0);
    n_tests++;
    if (f_cyc != PEN) begin
      n_fail++;
      $display("FAIL cold_penalty got=%0d exp=%0d", f_cyc, PEN);
    end
    n_tests++;
    if (f_nreq != 4) begin
      n_fail++;
      $display("FAIL cold_nreq got=%0d exp=4", f_nreq);
    end
    for (int w = 0; w < 4; w++) begin
      n_tests++;
      if (f_addr[w] !== 32'(4 * w)) begin
        n_fail++;
        $display("FAIL cold_addr%0d got=%h exp=%h", w, f_addr[w], 4 * w);
      end
      n_tests++;
      if (f_cd[w] !== exp_d[w]) begin
        n_fail++;
        $display("FAIL cold_cd%0d got=%h exp=%h", w, f_cd[w], exp_d[w]);
      end
    end
  endtask

  task automatic test_conflict();
    run_fill(32'h100);
    n_tests++;
    if (f_cyc != PEN) begin
      n_fail++;
      $display("FAIL conf_penalty got=%0d exp=%0d", f_cyc, PEN);
    end
    n_tests++;
    if (f_addr[0] !== 32'h100) begin
      n_fail++;
      $display("FAIL conf_addr got=%h exp=00000100", f_addr[0]);
    end
    for (int w = 0; w < 4; w++) begin
      n_tests++;
      if (f_cd[w] !== 32'hA500_0100 + 32'(4 * w)) begin
        n_fail++;
        $display("FAIL conf_cd%0d got=%h exp=%h",
                 w, f_cd[w], 32'hA500_0100 + 32'(4 * w));
      end
    end
    run_fill(32'h0);
    n_tests++;
    if (f_cyc != PEN) begin
      n_fail++;
      $display("FAIL conf_remiss got=%0d exp=%0d", f_cyc, PEN);
    end
    n_tests++;
    if (f_cd[3] !== 32'h44) begin
      n_fail++;
      $display("FAIL conf_recd3 got=%h exp=00000044", f_cd[3]);
    end
  endtask

  task automatic test_flush_idle();
    @(negedge Clk);
    Ifetch_WpPcIn    = 32'h0;
    Ifetch_ReadCache = 1'b1;
    IFQ_Flush        = 1'b1;
    #1;
    n_tests++;
    if (Cache_ReadHit !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_hit got=%b exp=0", Cache_ReadHit);
    end
    @(negedge Clk);
    IFQ_Flush = 1'b0;
    Ifetch_WpPcIn = 32'h40;
    Ifetch_ReadCache = 1'b0;
    #1;
    n_tests++;
    if (Imem_Req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_req got=%b exp=0", Imem_Req);
    end
    Ifetch_WpPcIn = 32'h0;
    Ifetch_ReadCache = 1'b1;
    #1;
    n_tests++;
    if (Cache_ReadHit !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle_after got=%b exp=1", Cache_ReadHit);
    end
    Ifetch_ReadCache = 1'b0;
  endtask

  task automatic test_flush_mid_fill();
    f_cyc  = -1;
    f_nreq = 0;
    @(negedge Clk);
    Ifetch_ReadCache = 1'b1;
    for (int i = 0; i < 60; i++) begin
      Ifetch_WpPcIn = (i >= 5 && i <= 8) ? 32'h30 : 32'h20;
      IFQ_Flush     = (i == 5);
      #1;
      if (Imem_Req === 1'b1 && f_nreq < 8) begin
        f_addr[f_nreq] = Imem_Addr;
        f_nreq++;
      end
      if (Cache_ReadHit === 1'b1) begin
        f_cyc = i;
        f_cd  = '{Cache_Cd0, Cache_Cd1, Cache_Cd2, Cache_Cd3};
        break;
      end
      @(negedge Clk);
    end
    Ifetch_ReadCache = 1'b0;
    IFQ_Flush = 1'b0;
    n_tests++;
    if (f_cyc != PEN) begin
      n_fail++;
      $display("FAIL midflush_first_hit got=%0d exp=%0d", f_cyc, PEN);
    end
    n_tests++;
    if (f_nreq != 4) begin
      n_fail++;
      $display("FAIL midflush_nreq got=%0d exp=4", f_nreq);
    end
    for (int w = 0; w < 4; w++) begin
      n_tests++;
      if (f_addr[w] !== 32'h20 + 32'(4 * w)) begin
        n_fail++;
        $display("FAIL midflush_addr%0d got=%h exp=%h",
                 w, f_addr[w], 32'h20 + 32'(4 * w));
      end
      n_tests++;
      if (f_cd[w] !== mem(32'h20 + 32'(4 * w))) begin
        n_fail++;
        $display("FAIL midflush_cd%0d got=%h exp=%h",
                 w, f_cd[w], mem(32'h20 + 32'(4 * w)));
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    @(negedge Clk);
    Ifetch_WpPcIn    = 32'h30;
    Ifetch_ReadCache = 1'b1;
    @(negedge Clk);
    Ifetch_ReadCache = 1'b0;
    @(negedge Clk);
    Resetb = 1'b0;
    @(negedge Clk);
    Resetb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (Imem_Req !== 1'b0) begin
        n_fail++;
        $display("FAIL rstfill_req%0d got=%b exp=0", i, Imem_Req);
      end
      @(negedge Clk);
    end
    run_fill(32'h0);
    n_tests++;
    if (f_cyc != PEN) begin
      n_fail++;
      $display("FAIL rstfill_0_miss got=%0d exp=%0d", f_cyc, PEN);
    end
    for (int w = 0; w < 4; w++) begin
      n_tests++;
      if (f_cd[w] !== 32'h11 * 32'(w + 1)) begin
        n_fail++;
        $display("FAIL rstfill_cd%0d got=%h exp=%h",
                 w, f_cd[w], 32'h11 * 32'(w + 1));
      end
    end
    run_fill(32'h30);
    n_tests++;
    if (f_cyc != PEN) begin
      n_fail++;
      $display("FAIL rstfill_30_miss got=%0d exp=%0d", f_cyc, PEN);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    run_fill(32'h10);
    run_fill(32'h20);
    @(negedge Clk);
    Ifetch_ReadCache = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i) << 4;
      Ifetch_WpPcIn = a;
      #1;
      n_tests++;
      if (Cache_ReadHit !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_hit%0d got=%b exp=1", i, Cache_ReadHit);
      end
      n_tests++;
      if (Imem_Req !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_req%0d got=%b exp=0", i, Imem_Req);
      end
      n_tests++;
      if (Cache_Cd0 !== mem(a) || Cache_Cd1 !== mem(a + 4) ||
          Cache_Cd2 !== mem(a + 8) || Cache_Cd3 !== mem(a + 12)) begin
        n_fail++;
        $display("FAIL b2b_data%0d got=%h %h %h %h exp=%h %h %h %h", i,
                 Cache_Cd0, Cache_Cd1, Cache_Cd2, Cache_Cd3,
                 mem(a), mem(a + 4), mem(a + 8), mem(a + 12));
      end
      @(negedge Clk);
    end
    Ifetch_ReadCache = 1'b0;
    #1;
    n_tests++;
    if (Imem_Req !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_req_after got=%b exp=0", Imem_Req);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_flush_idle();
    test_flush_mid_fill();
    test_reset_mid_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
